var_clause_walker: RTL and testbench

- Consumer stage of the per-variable start/end table.
- Accepts a variable ID from the decide/propagate controller and drives a read of the start/end table.
- Latches the returned clause-table range, then streams every clause-table index in that range to the clause fetch unit over a valid/ready handshake.
- Reports completion with a count, an error flag for malformed ranges, and supports mid-walk abort on conflict.

---
 rtl/var_clause_walker_if.sv | 45 ++++
 rtl/var_clause_walker.sv | 165 ++++++++++++++++
 tb/tb_var_clause_walker.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/var_clause_walker_if.sv
// rtl/var_clause_walker_if.sv - request, table, index-stream and completion signals of the clause walker
`ifndef MAX_VAR_BITS
`define MAX_VAR_BITS 16
`endif
`ifndef CLAUSE_TABLE_BITS
`define CLAUSE_TABLE_BITS 16
`endif

interface var_clause_walker_if #(
    parameter int VAR_BITS = `MAX_VAR_BITS,
    parameter int CT_BITS  = `CLAUSE_TABLE_BITS
);
    logic                req_valid;
    logic [VAR_BITS-1:0] req_var;
    logic                req_ready;

    logic                tbl_read;
    logic [VAR_BITS-1:0] tbl_var;
    logic [CT_BITS-1:0]  tbl_start;
    logic [CT_BITS-1:0]  tbl_end;

    logic                idx_valid;
    logic [CT_BITS-1:0]  idx_out;
    logic                idx_ready;

    logic                abort;

    logic                done_valid;
    logic [CT_BITS-1:0]  done_count;
    logic                done_err;
    logic                done_aborted;

    // master: controller, table and fetch unit side; slave: the walker
    modport master (
        output req_valid, req_var, tbl_start, tbl_end, idx_ready, abort,
        input  req_ready, tbl_read, tbl_var, idx_valid, idx_out,
               done_valid, done_count, done_err, done_aborted
    );

    modport slave (
        input  req_valid, req_var, tbl_start, tbl_end, idx_ready, abort,
        output req_ready, tbl_read, tbl_var, idx_valid, idx_out,
               done_valid, done_count, done_err, done_aborted
    );
endinterface

// File: rtl/var_clause_walker.sv
// rtl/var_clause_walker.sv - looks up a variable's clause range and streams every clause index in it
`ifndef MAX_VAR_BITS
`define MAX_VAR_BITS 16
`endif
`ifndef CLAUSE_TABLE_BITS
`define CLAUSE_TABLE_BITS 16
`endif

module var_clause_walker #(
    parameter int VAR_BITS = `MAX_VAR_BITS,
    parameter int CT_BITS  = `CLAUSE_TABLE_BITS
) (
    input logic                  clock,
    input logic                  reset,
    var_clause_walker_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        WALK   = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [CT_BITS-1:0] CT_ONE = {{(CT_BITS-1){1'b0}}, 1'b1};

    state_t              state;
    state_t              state_nx;

    logic [CT_BITS-1:0]  cur;
    logic [CT_BITS-1:0]  end_r;
    logic [CT_BITS-1:0]  count;
    logic [CT_BITS-1:0]  cur_nx;
    logic [CT_BITS-1:0]  count_nx;

    logic                accept;
    logic                handshake;
    logic                last_beat;
    logic                err_nx;
    logic                aborted_nx;

    logic                req_ready_d;
    logic                tbl_read_d;
    logic [VAR_BITS-1:0] tbl_var_d;
    logic                idx_valid_d;
    logic [CT_BITS-1:0]  idx_out_d;
    logic                done_valid_d;
    logic [CT_BITS-1:0]  done_count_d;
    logic                done_err_d;
    logic                done_aborted_d;

    // req_ready is only ever high in IDLE, so it doubles as the state qualifier
    assign accept    = bus.req_valid && bus.req_ready;
    assign handshake = bus.idx_valid && bus.idx_ready;
    assign last_beat = (cur + CT_ONE) == end_r;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        err_nx     = 1'b0;
        aborted_nx = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = LOOKUP;
                end
            end
            LOOKUP: begin
                if (bus.abort) begin
                    state_nx   = DONE;
                    aborted_nx = 1'b1;
                end else if (bus.tbl_end > bus.tbl_start) begin
                    state_nx = WALK;
                end else begin
                    state_nx = DONE;
                    err_nx   = bus.tbl_end < bus.tbl_start;
                end
            end
            WALK: begin
                if (bus.abort) begin
                    state_nx   = DONE;
                    aborted_nx = 1'b1;
                end else if (handshake && last_beat) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // A handshake coinciding with abort still advances cur/count
    always_comb begin
        cur_nx   = cur;
        count_nx = count;
        if (state == LOOKUP) begin
            cur_nx   = bus.tbl_start;
            count_nx = '0;
        end else if (state == WALK && handshake) begin
            cur_nx   = cur + CT_ONE;
            count_nx = count + CT_ONE;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cur   <= '0;
            end_r <= '0;
            count <= '0;
        end else begin
            cur   <= cur_nx;
            count <= count_nx;
            if (state == LOOKUP) begin
                end_r <= bus.tbl_end;
            end
        end
    end

    // Outputs are registered from the next state so each one is a clean Moore output
    always_comb begin
        req_ready_d    = (state_nx == IDLE);
        tbl_read_d     = (state_nx == LOOKUP);
        tbl_var_d      = (state_nx == LOOKUP) ? bus.req_var : '0;
        idx_valid_d    = (state_nx == WALK);
        idx_out_d      = (state_nx == WALK) ? cur_nx : '0;
        done_valid_d   = (state_nx == DONE);
        done_count_d   = (state_nx == DONE) ? count_nx : '0;
        done_err_d     = err_nx;
        done_aborted_d = aborted_nx;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bus.req_ready    <= 1'b0;
            bus.tbl_read     <= 1'b0;
            bus.tbl_var      <= '0;
            bus.idx_valid    <= 1'b0;
            bus.idx_out      <= '0;
            bus.done_valid   <= 1'b0;
            bus.done_count   <= '0;
            bus.done_err     <= 1'b0;
            bus.done_aborted <= 1'b0;
        end else begin
            bus.req_ready    <= req_ready_d;
            bus.tbl_read     <= tbl_read_d;
            bus.tbl_var      <= tbl_var_d;
            bus.idx_valid    <= idx_valid_d;
            bus.idx_out      <= idx_out_d;
            bus.done_valid   <= done_valid_d;
            bus.done_count   <= done_count_d;
            bus.done_err     <= done_err_d;
            bus.done_aborted <= done_aborted_d;
        end
    end
endmodule

// File: tb/tb_var_clause_walker.sv
// tb/tb_var_clause_walker.sv - randomized and directed bench for var_clause_walker against a trace model
`timescale 1ns/1ps

module tb_var_clause_walker;
    localparam int VB = 4;
    localparam int CB = 6;

    typedef struct packed {
        logic          req_ready;
        logic          tbl_read;
        logic [VB-1:0] tbl_var;
        logic          idx_valid;
        logic [CB-1:0] idx_out;
        logic          done_valid;
        logic [CB-1:0] done_count;
        logic          done_err;
        logic          done_aborted;
    } obs_t;

    logic clock;
    logic reset;
    int   cyc;
    int   errors;
    int   checks;

    logic [CB-1:0] tb_start [16];
    logic [CB-1:0] tb_end   [16];
    bit            rdy_pat  [256];
    bit            ab_pat   [256];
    obs_t          exp_tr   [int];

    var_clause_walker_if #(.VAR_BITS(VB), .CT_BITS(CB)) bus ();

    var_clause_walker #(.VAR_BITS(VB), .CT_BITS(CB)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    assign bus.tbl_start = tb_start[bus.tbl_var];
    assign bus.tbl_end   = tb_end[bus.tbl_var];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, expv);
        end
    endtask

    // One compare process: every cycle with a model record is checked field by field
    always @(negedge clock) begin
        obs_t act;
        obs_t ex;
        if (!reset && exp_tr.exists(cyc)) begin
            ex = exp_tr[cyc];
            exp_tr.delete(cyc);
            act.req_ready    = bus.req_ready;
            act.tbl_read     = bus.tbl_read;
            act.tbl_var      = bus.tbl_var;
            act.idx_valid    = bus.idx_valid;
            act.idx_out      = ex.idx_valid ? bus.idx_out : '0;
            act.done_valid   = bus.done_valid;
            act.done_count   = bus.done_count;
            act.done_err     = bus.done_err;
            act.done_aborted = bus.done_aborted;
            check("cycle_outputs", 64'(act), 64'(ex));
        end
    end

    task automatic pat_all_ready();
        for (int j = 0; j < 256; j++) begin
            rdy_pat[j] = 1'b1;
            ab_pat[j]  = 1'b0;
        end
    endtask

    task automatic pat_random();
        for (int j = 0; j < 256; j++) begin
            rdy_pat[j] = (j > 100) ? 1'b1 : ($urandom_range(0, 9) < 6);
            ab_pat[j]  = (j <= 100) && ($urandom_range(0, 19) == 0);
        end
    endtask

    // Builds the expected trace of one walk from the range rules, then drives it.
    // Called just after a posedge with the walker idle; returns after the DONE cycle.
    task automatic walk(input logic [VB-1:0] v, output int d_out, output int cnt_out);
        int   s;
        int   e;
        int   cnt;
        int   d;
        int   base;
        bit   aborted;
        bit   err;
        obs_t r;
        s       = int'(tb_start[v]);
        e       = int'(tb_end[v]);
        base    = cyc;
        cnt     = 0;
        d       = 0;
        aborted = 1'b0;
        err     = 1'b0;
        r = '0; r.req_ready = 1'b1;
        exp_tr[base] = r;
        r = '0; r.tbl_read = 1'b1; r.tbl_var = v;
        exp_tr[base + 1] = r;
        if (ab_pat[1]) begin
            d = 2; aborted = 1'b1;
        end else if (e <= s) begin
            d = 2; err = (e < s);
        end else begin
            for (int j = 2; j < 250; j++) begin
                r = '0; r.idx_valid = 1'b1; r.idx_out = CB'(s + cnt);
                exp_tr[base + j] = r;
                if (rdy_pat[j]) cnt++;
                if (ab_pat[j] || (s + cnt == e)) begin
                    d = j + 1;
                    aborted = ab_pat[j];
                    break;
                end
            end
        end
        r = '0; r.done_valid = 1'b1; r.done_count = CB'(cnt);
        r.done_err = err; r.done_aborted = aborted;
        exp_tr[base + d] = r;
        for (int j = 0; j <= d; j++) begin
            bus.req_valid = (j == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            bus.req_var   = (j == 0) ? v : VB'($urandom);
            bus.idx_ready = rdy_pat[j];
            bus.abort     = ab_pat[j];
            @(posedge clock); #1;
        end
        bus.req_valid = 1'b0;
        bus.abort     = 1'b0;
        d_out   = d;
        cnt_out = cnt;
    endtask

    initial begin
        int d;
        int c;
        errors = 0;
        checks = 0;
        reset  = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_var   = '0;
        bus.idx_ready = 1'b0;
        bus.abort     = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tb_start[i] = '0;
            tb_end[i]   = '0;
        end
        tb_start[5]  = 6'd3;  tb_end[5]  = 6'd6;
        tb_start[7]  = 6'd4;  tb_end[7]  = 6'd4;
        tb_start[2]  = 6'd9;  tb_end[2]  = 6'd3;
        tb_start[8]  = 6'd10; tb_end[8]  = 6'd14;
        tb_start[9]  = 6'd0;  tb_end[9]  = 6'd8;
        tb_start[10] = 6'd5;  tb_end[10] = 6'd9;
        tb_start[11] = 6'd1;  tb_end[11] = 6'd2;

        repeat (2) @(posedge clock);
        #1;
        check("reset_outputs",
              {bus.req_ready, bus.tbl_read, bus.idx_valid, bus.done_valid,
               bus.done_err, bus.done_aborted, bus.idx_out, bus.done_count},
              '0);
        reset = 1'b0;
        @(posedge clock); #1;
        check("req_ready_after_reset", bus.req_ready, 1'b1);

        pat_all_ready();
        walk(4'd5, d, c);
        check("model_var5_done_cycle", d, 5);
        check("model_var5_count", c, 3);

        walk(4'd7, d, c);
        check("model_var7_done_cycle", d, 2);
        walk(4'd0, d, c);
        check("model_var0_count", c, 0);
        walk(4'd2, d, c);
        check("model_var2_done_cycle", d, 2);

        pat_all_ready();
        rdy_pat[2] = 1; rdy_pat[3] = 0; rdy_pat[4] = 0; rdy_pat[5] = 1;
        rdy_pat[6] = 1; rdy_pat[7] = 0; rdy_pat[8] = 1;
        walk(4'd8, d, c);
        check("model_stall_done_cycle", d, 9);
        check("model_stall_count", c, 4);

        pat_all_ready();
        ab_pat[4] = 1'b1;
        walk(4'd9, d, c);
        check("model_abort_done_cycle", d, 5);
        check("model_abort_count", c, 3);
        check("req_ready_after_abort", bus.req_ready, 1'b1);

        // Reset in the middle of walking {5, 9}, while idx 5 is presented
        bus.req_valid = 1'b1; bus.req_var = 4'd10; bus.idx_ready = 1'b0;
        @(posedge clock); #1;
        bus.req_valid = 1'b0;
        @(posedge clock); #1;
        check("reset_walk_idx_valid", bus.idx_valid, 1'b1);
        check("reset_walk_idx_out", bus.idx_out, 6'd5);
        #2 reset = 1'b1;
        #1;
        check("reset_async_idx_valid", bus.idx_valid, 1'b0);
        check("reset_async_done_valid", bus.done_valid, 1'b0);
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;
        check("req_ready_after_midwalk_reset", bus.req_ready, 1'b1);
        pat_all_ready();
        walk(4'd11, d, c);
        check("model_var11_count", c, 1);

        for (int w = 0; w < 40; w++) begin
            for (int k = 12; k < 16; k++) begin
                int sel;
                tb_start[k] = CB'($urandom_range(0, 50));
                sel = $urandom_range(0, 9);
                if (sel < 2)
                    tb_end[k] = CB'($urandom_range(0, 50));
                else if (sel < 3)
                    tb_end[k] = tb_start[k];
                else
                    tb_end[k] = tb_start[k] + CB'($urandom_range(1, 10));
            end
            pat_random();
            walk(VB'($urandom_range(0, 15)), d, c);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clock); #1;
            end
        end

        repeat (3) @(posedge clock);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
